ov7670_capture_gen: RTL and testbench
=====================================

OV7670_CAPTURE_GEN -- requirements
Module: ov7670_capture_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 The block SHALL have parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 The block SHALL have parameter ADDR_W, default 19: write-address width, sized so that 2^ADDR_W >= H_ACTIVE*V_ACTIVE.
REQ-004 The block SHALL have port ipclk, input, 1 bit: the single clock (camera pixel clock); all logic is on its rising edge.
REQ-005 The block SHALL have port ireset, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have ports ivsync and ihref, inputs, 1 bit each: camera frame and line sync.
REQ-007 The block SHALL have port idata, input, 8 bits: camera byte stream.
REQ-008 The block SHALL have port ienable, input, 1 bit: capture arm.
REQ-009 The block SHALL have port imode, input, 2 bits: pixel format (0 RGB565, 1 RGB555, 2 YUV422 luma, 3 raw).
REQ-010 The block SHALL have port idecim, input, 1 bit: 2x2 decimation enable.
REQ-011 The block SHALL have port owr_en, output, 1 bit: frame-buffer write strobe.
REQ-012 The block SHALL have port oaddr, output, ADDR_W bits: write address.
REQ-013 The block SHALL have port odata_out, output, 24 bits: pixel data {R8,G8,B8}.
REQ-014 The block SHALL have port oframe_done, output, 1 bit: one-cycle end-of-frame pulse.
REQ-015 The block SHALL have port oline_err, output, 1 bit: sticky geometry-overflow flag.
REQ-016 The block SHALL have port oframe_cnt, output, 8 bits: count of completed frames.

Function
REQ-017 The FSM SHALL have four states: IDLE, WAIT_VS, CAPTURE, FRAME_END.
REQ-018 IDLE SHALL go to WAIT_VS when ienable=1.
REQ-019 WAIT_VS SHALL go to CAPTURE on the first ivsync 1->0 transition, detected against a registered copy of ivsync.
REQ-020 On the WAIT_VS->CAPTURE transition, the block SHALL latch imode and idecim, and clear the address, pixel and line counters, the byte phase, and oline_err.
REQ-021 CAPTURE SHALL go to FRAME_END on an ivsync 0->1 transition.
REQ-022 FRAME_END SHALL last one cycle, with oframe_done=1 and oframe_cnt incremented (255 wraps to 0), then go to WAIT_VS if ienable=1, else to IDLE.
REQ-023 Deasserting ienable during CAPTURE SHALL NOT abort the frame: the frame completes, then the FSM goes to IDLE.
REQ-024 Bytes SHALL be sampled only in CAPTURE with ihref=1; byte phase toggles 0/1 per sampled byte and is forced to 0 while ihref=0.
REQ-025 A pixel SHALL complete on the phase-1 byte; an odd trailing byte at line end SHALL be discarded without a write.
REQ-026 The pixel counter SHALL increment per completed pixel and clear on ihref 1->0; the line counter SHALL increment on each ihref 1->0 transition.
REQ-027 Conversion, with b0 = phase-0 byte and b1 = phase-1 byte:
- mode 0: R5=b0[7:3], G6={b0[2:0],b1[7:5]}, B5=b1[4:0].
- mode 1: R5=b0[6:2], G5={b0[1:0],b1[7:5]}, B5=b1[4:0].
- Expansion to 8 bits SHALL replicate MSBs, e.g. R8={R5,R5[4:2]}, G8={G6,G6[5:4]}.
- mode 2: odata_out={b0,b0,b0} (YUYV order, Y in b0).
- mode 3: odata_out={8'h00,b0,b1}.
REQ-028 owr_en SHALL pulse one cycle, registered: asserted the cycle after the phase-1 byte edge, with odata_out and oaddr valid in that same cycle.
REQ-029 oaddr SHALL start at 0 each frame and increment by 1 after each write.
REQ-030 With idecim=1, only even pixel indices on even line indices SHALL be written; the frame maximum SHALL be (H_ACTIVE/2)*(V_ACTIVE/2) writes.
REQ-031 A pixel with index >= H_ACTIVE, or on a line with index >= V_ACTIVE, SHALL NOT be written and SHALL set oline_err=1 until the next frame start.
REQ-032 oaddr SHALL never exceed H_ACTIVE*V_ACTIVE-1.
REQ-033 odata_out SHALL hold its last value when owr_en=0.

Reset
REQ-034 While ireset=1 at a clock edge, the block SHALL enter IDLE and set owr_en, oaddr, odata_out, oframe_done, oline_err, oframe_cnt and all counters to 0.
REQ-035 Reset mid-frame SHALL abandon that frame; after release, capture SHALL wait for a full ivsync high->low transition before writing.

Verification
REQ-036 The bench SHALL run with H_ACTIVE=4, V_ACTIVE=2, mode 0, and bytes F8,00 -> owr_en pulse with odata_out=FF0000 and oaddr=0; the next bytes 07,E0 -> odata_out=00FF00 and oaddr=1.
REQ-037 The bench SHALL send a full 4x2 frame -> 8 writes, oaddr 0..7, one oframe_done pulse on the ivsync rise, and oframe_cnt=1.
REQ-038 The bench SHALL send a line of 5 pixels, then a 3rd line -> 8 writes only and oline_err=1; oline_err SHALL clear at the next frame start.
REQ-039 The bench SHALL run with idecim=1, mode 2, and a 4x2 frame with Y bytes 10,20,30,40 on line 0 -> 2 writes, odata_out=101010 then 303030, oaddr 0..1.
REQ-040 The bench SHALL send an odd byte count per line (7 bytes) -> 3 writes per line, and the next line SHALL start at byte phase 0.
REQ-041 The bench SHALL assert ireset during pixel 2 and drop ienable mid-frame on a later frame -> all outputs 0, no writes until a new ivsync fall, and the FSM SHALL return to IDLE after that frame's oframe_done.

Source files
------------

// File: rtl/ov7670_capture_gen.sv
// ov7670_capture_gen: OV7670 byte-stream capture into a linear RGB888 frame-buffer write port
module ov7670_capture_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W = 19
) (
  input  logic              ipclk,
  input  logic              ireset,
  input  logic              ivsync,
  input  logic              ihref,
  input  logic [7:0]        idata,
  input  logic              ienable,
  input  logic [1:0]        imode,
  input  logic              idecim,
  output logic              owr_en,
  output logic [ADDR_W-1:0] oaddr,
  output logic [23:0]       odata_out,
  output logic              oframe_done,
  output logic              oline_err,
  output logic [7:0]        oframe_cnt
);
  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, FRAME_END} state_t;
  localparam logic [15:0] H_MAX = 16'(H_ACTIVE);
  localparam logic [15:0] V_MAX = 16'(V_ACTIVE);
  state_t state;
  logic vs_d, href_d, phase, decim;
  logic [1:0] mode;
  logic [7:0] b0, g8;
  logic [4:0] r5;
  logic [15:0] pix_cnt, line_cnt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [23:0] pixel;
  logic in_geom, keep, pixel_done;
  always_comb begin
    r5 = mode[0] ? b0[6:2] : b0[7:3];
    g8 = mode[0] ? {b0[1:0], idata[7:5], b0[1:0], idata[7]} : {b0[2:0], idata[7:5], b0[2:1]};
    pixel = mode == 2'd2 ? {b0, b0, b0} :
            mode == 2'd3 ? {8'h00, b0, idata} :
            {r5, r5[4:2], g8, idata[4:0], idata[4:2]};
    in_geom = pix_cnt < H_MAX && line_cnt < V_MAX;
    keep = in_geom && (!decim || !(pix_cnt[0] | line_cnt[0]));
    pixel_done = state == CAPTURE && ihref && phase;
  end
  always_ff @(posedge ipclk) begin
    if (ireset) begin
      state <= IDLE;
      vs_d <= 1'b0;
      href_d <= 1'b0;
      phase <= 1'b0;
      decim <= 1'b0;
      mode <= 2'd0;
      b0 <= 8'h00;
      pix_cnt <= 16'd0;
      line_cnt <= 16'd0;
      addr_cnt <= '0;
      owr_en <= 1'b0;
      oaddr <= '0;
      odata_out <= 24'h0;
      oframe_done <= 1'b0;
      oline_err <= 1'b0;
      oframe_cnt <= 8'h00;
    end else begin
      vs_d <= ivsync;
      href_d <= ihref;
      owr_en <= 1'b0;
      oframe_done <= 1'b0;
      case (state)
        IDLE: if (ienable) state <= WAIT_VS;
        WAIT_VS: if (vs_d && !ivsync) begin
          state <= CAPTURE;
          mode <= imode;
          decim <= idecim;
          addr_cnt <= '0;
          oaddr <= '0;
          pix_cnt <= 16'd0;
          line_cnt <= 16'd0;
          phase <= 1'b0;
          oline_err <= 1'b0;
        end
        CAPTURE: begin
          if (!vs_d && ivsync) begin
            state <= FRAME_END;
            oframe_done <= 1'b1;
            oframe_cnt <= oframe_cnt + 8'd1;
          end
          phase <= ihref && !phase;
          if (ihref && !phase) b0 <= idata;
          if (pixel_done) begin
            // counters saturate so an overlong line can never wrap back into range
            if (pix_cnt != '1) pix_cnt <= pix_cnt + 16'd1;
            if (!in_geom) oline_err <= 1'b1;
            if (keep) begin
              owr_en <= 1'b1;
              oaddr <= addr_cnt;
              odata_out <= pixel;
              addr_cnt <= addr_cnt + ADDR_W'(1);
            end
          end
          if (href_d && !ihref) begin
            pix_cnt <= 16'd0;
            if (line_cnt != '1) line_cnt <= line_cnt + 16'd1;
          end
        end
        FRAME_END: state <= ienable ? WAIT_VS : IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ov7670_capture_gen.sv
// tb_ov7670_capture_gen: directed + randomized frames checked against a per-pixel reference model
module tb_ov7670_capture_gen;
  localparam int H = 4, V = 2, AW = 3;
  logic ipclk = 1'b0, ireset = 1'b1, ivsync = 1'b0, ihref = 1'b0, ienable = 1'b0, idecim = 1'b0;
  logic [7:0] idata = 8'h00;
  logic [1:0] imode = 2'd0;
  logic owr_en, oframe_done, oline_err;
  logic [AW-1:0] oaddr;
  logic [23:0] odata_out;
  logic [7:0] oframe_cnt;
  int n_assert = 0, n_fail = 0, n_done = 0, d0 = 0;
  int mode_e = 0, addr_e = 0, cnt_e = 0;
  bit dec_e = 0, err_e = 0, arm_e = 1;
  int lb[$];
  logic [31:0] act_q[$], exp_q[$];

  ov7670_capture_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .ipclk(ipclk), .ireset(ireset), .ivsync(ivsync), .ihref(ihref), .idata(idata),
    .ienable(ienable), .imode(imode), .idecim(idecim), .owr_en(owr_en), .oaddr(oaddr),
    .odata_out(odata_out), .oframe_done(oframe_done), .oline_err(oline_err), .oframe_cnt(oframe_cnt)
  );

  always #5 ipclk = ~ipclk;

  always @(negedge ipclk) begin
    if (owr_en) act_q.push_back({5'b0, oaddr, odata_out});
    if (oframe_done) n_done++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge ipclk);
  endtask

  function automatic logic [23:0] conv(input int m, input int b0, input int b1);
    int r, g, b;
    if (m == 2) return {8'(b0), 8'(b0), 8'(b0)};
    if (m == 3) return {8'h00, 8'(b0), 8'(b1)};
    b = b1 % 32;
    r = (m == 0) ? b0 / 8 : (b0 / 4) % 32;
    g = (m == 0) ? (b0 % 8) * 8 + b1 / 32 : (b0 % 4) * 8 + b1 / 32;
    return {8'(r * 8 + r / 4), 8'((m == 0) ? g * 4 + g / 16 : g * 8 + g / 4), 8'(b * 8 + b / 4)};
  endfunction

  task automatic rnd(input int n);
    lb.delete();
    repeat (n) lb.push_back(int'($urandom_range(0, 255)));
  endtask

  task automatic model_line(input int l);
    for (int p = 0; p < lb.size() / 2; p++)
      if (arm_e && p < H && l < V && (!dec_e || (p % 2 == 0 && l % 2 == 0))) begin
        exp_q.push_back({5'b0, AW'(addr_e), conv(mode_e, lb[2*p], lb[2*p+1])});
        addr_e++;
      end else if (arm_e && (p >= H || l >= V)) err_e = 1;
  endtask

  task automatic drive_bytes();
    foreach (lb[i]) begin
      ihref = 1'b1;
      idata = 8'(lb[i]);
      tick(1);
    end
  endtask

  task automatic send(input int l);
    model_line(l);
    drive_bytes();
    ihref = 1'b0;
    idata = 8'($urandom);
    tick(3);
  endtask

  task automatic start_frame(input int m, input bit d);
    imode = 2'(m);
    idecim = d;
    mode_e = m;
    dec_e = d;
    addr_e = 0;
    err_e = 0;
    exp_q.delete();
    act_q.delete();
    d0 = n_done;
    ivsync = 1'b1;
    tick(3);
    ivsync = 1'b0;
    tick(3);
    check("err_clr", 32'(oline_err), 32'(0));
  endtask

  task automatic end_frame(input string tag);
    ivsync = 1'b1;
    tick(4);
    if (arm_e) cnt_e = (cnt_e + 1) % 256;
    check({tag, "_nwr"}, act_q.size(), exp_q.size());
    foreach (exp_q[i]) check({tag, "_wr"}, act_q[i], exp_q[i]);
    check({tag, "_done"}, n_done - d0, 32'(arm_e));
    check({tag, "_err"}, 32'(oline_err), 32'(err_e));
    check({tag, "_cnt"}, 32'(oframe_cnt), cnt_e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wr_en"}, 32'(owr_en), 0);
    check({tag, "_addr"}, 32'(oaddr), 0);
    check({tag, "_data"}, 32'(odata_out), 0);
    check({tag, "_done"}, 32'(oframe_done), 0);
    check({tag, "_err"}, 32'(oline_err), 0);
    check({tag, "_cnt"}, 32'(oframe_cnt), 0);
  endtask

  initial begin
    tick(3);
    check_zero("reset");
    ireset = 1'b0;
    ienable = 1'b1;
    tick(2);
    // known RGB565 pixels, then the rest of a full 4x2 frame
    start_frame(0, 0);
    lb = {'hF8, 'h00, 'h07, 'hE0};
    repeat (4) lb.push_back(int'($urandom_range(0, 255)));
    send(0);
    check("px0", act_q[0], 32'h00FF0000);
    check("px1", act_q[1], 32'h0100FF00);
    rnd(8); send(1);
    end_frame("full");
    // overlong line and an extra line
    start_frame(int'($urandom_range(0, 1)), 0);
    rnd(10); send(0);
    rnd(8); send(1);
    rnd(8); send(2);
    end_frame("ovf");
    // decimated luma
    start_frame(2, 1);
    lb = {'h10, 'h80, 'h20, 'h80, 'h30, 'h80, 'h40, 'h80};
    send(0);
    rnd(8); send(1);
    check("dec0", act_q[0], 32'h00101010);
    check("dec1", act_q[1], 32'h01303030);
    end_frame("decim");
    // odd byte count per line
    start_frame(int'($urandom_range(0, 3)), 0);
    rnd(7); send(0);
    rnd(7); send(1);
    end_frame("odd");
    for (int f = 0; f < 4; f++) begin
      start_frame(int'($urandom_range(0, 3)), 1'($urandom));
      rnd(8); send(0);
      rnd(8); send(1);
      end_frame("rand");
    end
    // reset during pixel 2
    start_frame(0, 0);
    rnd(5);
    model_line(0);
    drive_bytes();
    ireset = 1'b1;
    tick(2);
    check_zero("midrst");
    check("midrst_nwr", act_q.size(), 2);
    ireset = 1'b0;
    arm_e = 0;
    cnt_e = 0;
    rnd(3); drive_bytes();
    ihref = 1'b0;
    tick(3);
    rnd(8); send(1);
    end_frame("rst");
    // ienable dropped mid-frame: frame completes, then idle
    arm_e = 1;
    start_frame(1, 0);
    rnd(8); send(0);
    ienable = 1'b0;
    rnd(8); send(1);
    end_frame("drop_en");
    arm_e = 0;
    start_frame(3, 0);
    rnd(8); send(0);
    rnd(8); send(1);
    end_frame("idle");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
